// File: rtl/generador_codigogray.sv
// 4-bit Gray code generator with manual (button) and automatic (prescaler)
// stepping, synchronous load and one-cycle valid/wrap pulses.
//
// Optional build macro GRAY_DEBOUNCE_EN: when defined, the synchronized
// button level must stay stable for DEB_CYCLES clocks before it is accepted,
// and the step comes from the rising edge of that debounced level. When the
// macro is undefined the step comes straight from the synchronizer edge and
// DEB_CYCLES has no effect.
//
// Manual timing (no debounce): paso sampled high at edge 1 -> s1, edge 2 ->
// s2 (edge detected as s2 & ~s3), edge 3 -> gray/bin/valido update.
module generador_codigogray #(
    parameter int unsigned DIV        = 32'd50_000_000,
    parameter int unsigned DEB_CYCLES = 32'd1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       modo,
    input  logic       dir,
    input  logic       paso,
    input  logic       cargar,
    input  logic [3:0] b,
    output logic [3:0] gray,
    output logic [3:0] bin,
    output logic       valido,
    output logic       vuelta
);

    // Binary to reflected Gray conversion.
    function automatic logic [3:0] to_gray(input logic [3:0] v);
        return v ^ (v >> 1);
    endfunction

    // Button synchronizer chain; reset to 1 so a button held through reset
    // release does not look like a fresh press.
    logic s1;
    logic s2;
    logic s3;

    // Rising edge of the (optionally debounced) button level.
    logic edge_event;

    // Auto-mode prescaler and step requests.
    logic [31:0] presc;
    logic        auto_step;
    logic        manual_step;
    logic        step;

    // Candidate next count for a step, and whether that step wraps.
    logic [3:0] next_bin;
    logic       wrap;

    // Shift the asynchronous button through three flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= paso;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef GRAY_DEBOUNCE_EN
    logic [31:0] deb_cnt;
    logic        deb_level;
    logic        deb_prev;

    // Accept a new button level only after it has differed from the current
    // debounced level for DEB_CYCLES consecutive cycles; any bounce back
    // restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b1;
            deb_prev  <= 1'b1;
        end else begin
            deb_prev <= deb_level;
            if (s3 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_CYCLES - 32'd1) begin
                deb_level <= s3;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 32'd1;
            end
        end
    end

    assign edge_event = deb_level & ~deb_prev;
`else
    // Without debounce the raw synchronized edge is the step event.
    assign edge_event = s2 & ~s3;

    // DEB_CYCLES is a configuration value that only matters with debounce.
    if (DEB_CYCLES == 32'd0) begin : g_deb_cycles_unused
    end
`endif

    // Button steps only count in manual mode; prescaler steps only in auto.
    assign manual_step = ~modo & edge_event;
    assign auto_step   = modo & (presc == DIV - 32'd1);
    assign step        = manual_step | auto_step;

    // Prescaler runs 0..DIV-1 in auto mode, parked at 0 in manual mode and
    // restarted by a load so the next auto step is a full period away.
    always_ff @(posedge clk) begin
        if (rst || cargar || !modo) begin
            presc <= '0;
        end else if (presc == DIV - 32'd1) begin
            presc <= '0;
        end else begin
            presc <= presc + 32'd1;
        end
    end

    // Next count and wrap flag for a step in the requested direction.
    always_comb begin
        next_bin = bin;
        wrap     = 1'b0;
        if (dir) begin
            next_bin = bin + 4'd1;
            wrap     = (bin == 4'hF);
        end else begin
            next_bin = bin - 4'd1;
            wrap     = (bin == 4'h0);
        end
    end

    // Count register and pulses: reset beats load, load beats (and discards)
    // a simultaneous step.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin    <= 4'h0;
            gray   <= 4'h0;
            valido <= 1'b0;
            vuelta <= 1'b0;
        end else if (cargar) begin
            bin    <= b;
            gray   <= to_gray(b);
            valido <= 1'b1;
            vuelta <= 1'b0;
        end else if (step) begin
            bin    <= next_bin;
            gray   <= to_gray(next_bin);
            valido <= 1'b1;
            vuelta <= wrap;
        end else begin
            valido <= 1'b0;
            vuelta <= 1'b0;
        end
    end

endmodule
